// File: rtl/dmem_stall_ctrl_pkg.sv
// Shared definitions for the data-memory stall controller: opcode constants,
// funct3 access size/sign encodings, and the access FSM state encoding.
package dmem_stall_ctrl_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // funct3[1:0] is log2(access bytes); funct3[2] selects zero-extension.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: store data / byte-enable placement and
// misalignment detection for the access being issued, and load-data
// extraction plus sign/zero extension for the access in flight.
module dmem_lane_align
  import dmem_stall_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [2:0]      req_funct3_i,
  input  logic            req_store_i,
  input  logic [OFFW-1:0] req_off_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] wdata_o,
  output logic [NB-1:0]   be_o,
  output logic            misalign_o,
  input  logic [2:0]      ld_funct3_i,
  input  logic [OFFW-1:0] ld_off_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] load_data_o
);

  logic [1:0]             req_size;
  logic [4:0]             req_bytes;
  logic [15:0]            req_mask;
  logic [OFFW-1:0]        low_mask;
  logic                   illegal;
  logic [4:0]             ld_bytes;
  logic [7:0]             ld_pad;
  logic [XLEN-1:0]        ld_shifted;
  logic [XLEN-1:0]        ld_top;
  logic signed [XLEN-1:0] ld_sext;

  // Request side: lane placement, byte enables and alignment check.
  always_comb begin
    req_size  = req_funct3_i[1:0];
    req_bytes = 5'd1 << req_size;
    req_mask  = (16'd1 << req_bytes) - 16'd1;
    low_mask  = OFFW'((4'd1 << req_size) - 4'd1);
    // Unsigned store sizes, funct3=111, and 64-bit sizes on a 32-bit core
    // are not real accesses; they take the error path like a misalignment.
    illegal   = (req_funct3_i == 3'b111) ||
                (req_store_i && req_funct3_i[2]) ||
                ((XLEN == 32) && ((req_size == 2'b11) || (req_funct3_i == F3_WU)));
    misalign_o = illegal || (|(req_off_i & low_mask));
    be_o       = req_mask[NB-1:0] << req_off_i;
    wdata_o    = wdata_i << {req_off_i, 3'b000};
  end

  // Load side: move the addressed bytes to bit 0, then extend to XLEN.
  always_comb begin
    ld_bytes   = 5'd1 << ld_funct3_i[1:0];
    ld_pad     = 8'(XLEN) - {ld_bytes, 3'b000};
    ld_shifted = rdata_i >> {ld_off_i, 3'b000};
    ld_top     = ld_shifted << ld_pad;
    ld_sext    = $signed(ld_top) >>> ld_pad;
    if (ld_funct3_i[2]) begin
      load_data_o = ld_top >> ld_pad;
    end else begin
      load_data_o = ld_sext;
    end
  end

endmodule

// File: rtl/dmem_stall_ctrl.sv
// Variable-latency data-memory access controller. Decodes load/store,
// issues one valid/ready transaction, stalls the PC and gates write-back
// until the access completes.
// Optional feature macro: DMEM_TIMEOUT_EN adds a REQ-cycle counter and a
// one-cycle bus_err output when memory never answers.
//
// Handshake: dmem_req is high for every REQ cycle; addr/we/wdata/be are
// registered on entry to REQ and never change while dmem_req=1. A beat
// completes on the edge where dmem_req=1 and dmem_ready=1; dmem_rdata is
// sampled only on that edge. dmem_ready outside REQ is ignored.
module dmem_stall_ctrl
  import dmem_stall_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              reg_write_in,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata_in,
  output logic              pc_enable,
  output logic              reg_write_out,
  output logic [XLEN-1:0]   load_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN/8-1:0] dmem_be,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              misalign_err,
`ifdef DMEM_TIMEOUT_EN
  output logic              bus_err,
`endif
  output state_t            dbg_state
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  state_t            state_q, state_d;
  logic              we_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [NB-1:0]     be_q;
  logic [2:0]        funct3_q;
  logic [OFFW-1:0]   off_q;
  logic              mis_q;
  logic              ld_ok_q;
  logic              tmo_q;
  logic [XLEN-1:0]   load_data_q;

  logic              is_mem;
  logic              is_store;
  logic              mis;
  logic              timed_out;
  logic [XLEN-1:0]   align_wdata;
  logic [NB-1:0]     align_be;
  logic [XLEN-1:0]   ext_rdata;

  assign is_store = (opcode == OP_STORE);
  assign is_mem   = is_mem_op(opcode);

  dmem_lane_align #(.XLEN(XLEN)) u_align (
    .req_funct3_i (funct3),
    .req_store_i  (is_store),
    .req_off_i    (addr[OFFW-1:0]),
    .wdata_i      (wdata_in),
    .wdata_o      (align_wdata),
    .be_o         (align_be),
    .misalign_o   (mis),
    .ld_funct3_i  (funct3_q),
    .ld_off_i     (off_q),
    .rdata_i      (dmem_rdata),
    .load_data_o  (ext_rdata)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt_q;

  assign timed_out = (state_q == ST_REQ) && !dmem_ready &&
                     (tmo_cnt_q == CW'(TIMEOUT_CYC - 1));
  assign bus_err   = (state_q == ST_DONE) && tmo_q;

  // Count REQ cycles; cleared whenever REQ is entered.
  always_ff @(posedge clk) begin
    if (rst || state_q != ST_REQ) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and stall / handshake outputs.
  always_comb begin
    state_d       = state_q;
    pc_enable     = 1'b0;
    reg_write_out = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (is_mem) begin
          state_d = mis ? ST_DONE : ST_REQ;
        end else begin
          pc_enable     = 1'b1;
          reg_write_out = reg_write_in;
        end
      end
      ST_REQ: begin
        if (dmem_ready || timed_out) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d       = ST_IDLE;
        pc_enable     = 1'b1;
        reg_write_out = reg_write_in && ld_ok_q;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      pc_enable     = 1'b0;
      reg_write_out = 1'b0;
    end
  end

  // Request fields latch on IDLE->REQ; load data latches on the ready beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
      mis_q       <= 1'b0;
      ld_ok_q     <= 1'b0;
      tmo_q       <= 1'b0;
      load_data_q <= '0;
    end else if (state_q == ST_IDLE && is_mem) begin
      mis_q   <= mis;
      ld_ok_q <= 1'b0;
      tmo_q   <= 1'b0;
      if (!mis) begin
        we_q     <= is_store;
        addr_q   <= {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
        wdata_q  <= align_wdata;
        be_q     <= align_be;
        funct3_q <= funct3;
        off_q    <= addr[OFFW-1:0];
      end
    end else if (state_q == ST_REQ) begin
      if (dmem_ready) begin
        ld_ok_q <= !we_q;
        if (!we_q) begin
          load_data_q <= ext_rdata;
        end
      end else if (timed_out) begin
        tmo_q <= 1'b1;
      end
    end
  end

  assign dmem_req     = (state_q == ST_REQ);
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign load_data    = load_data_q;
  assign misalign_err = (state_q == ST_DONE) && mis_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Bench for dmem_stall_ctrl (XLEN=32): table of load/store vectors with
// hand-derived expectations, load results via an expected queue, plus
// sequences for reset mid-access, ready-in-IDLE and the optional timeout.
module tb_dmem_stall_ctrl;
  import dmem_stall_ctrl_pkg::*;

  localparam int XLEN = 32;
  localparam logic [6:0] OP_ADD = 7'b0110011;

  logic              clk = 1'b0;
  logic              rst;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              reg_write_in;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata_in;
  logic              pc_enable;
  logic              reg_write_out;
  logic [XLEN-1:0]   load_data;
  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic [XLEN/8-1:0] dmem_be;
  logic              dmem_ready;
  logic [XLEN-1:0]   dmem_rdata;
  logic              misalign_err;
`ifdef DMEM_TIMEOUT_EN
  logic              bus_err;
`endif
  state_t            dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [XLEN-1:0] exp_q[$];

  dmem_stall_ctrl #(.XLEN(XLEN), .TIMEOUT_CYC(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .funct3        (funct3),
    .reg_write_in  (reg_write_in),
    .addr          (addr),
    .wdata_in      (wdata_in),
    .pc_enable     (pc_enable),
    .reg_write_out (reg_write_out),
    .load_data     (load_data),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_be       (dmem_be),
    .dmem_ready    (dmem_ready),
    .dmem_rdata    (dmem_rdata),
    .misalign_err  (misalign_err),
`ifdef DMEM_TIMEOUT_EN
    .bus_err       (bus_err),
`endif
    .dbg_state     (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        rwi;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wait_n;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
    logic        exp_rwo;
    logic        exp_mis;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic rwi,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                              input int wn, input logic ereq, input logic [31:0] eaddr,
                              input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eld,
                              input logic erwo, input logic emis);
    vec_t v;
    v.op = op; v.f3 = f3; v.rwi = rwi; v.addr = a; v.wdata = wd; v.rdata = rd;
    v.wait_n = wn; v.exp_req = ereq; v.exp_addr = eaddr; v.exp_be = ebe;
    v.exp_wdata = ewd; v.exp_load = eld; v.exp_rwo = erwo; v.exp_mis = emis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    opcode       = OP_ADD;
    funct3       = 3'b000;
    reg_write_in = 1'b0;
    dmem_ready   = 1'b0;
  endtask

  // One full access from IDLE back to IDLE; called right after a negedge.
  task automatic do_access(input int idx, input vec_t v);
    int n;
    int wn;
    wn = (v.wait_n == 0) ? int'($urandom_range(1, 5)) : v.wait_n;
    opcode = v.op; funct3 = v.f3; reg_write_in = v.rwi;
    addr = v.addr; wdata_in = v.wdata; dmem_ready = 1'b0;
    #1;
    chk($sformatf("v%0d_idle_pc", idx), 64'(pc_enable), 64'd0);
    chk($sformatf("v%0d_idle_rwo", idx), 64'(reg_write_out), 64'd0);
    if (v.exp_req && v.op == OP_LOAD) exp_q.push_back(v.exp_load);
    step();
    if (v.exp_req) begin
      chk($sformatf("v%0d_state_req", idx), 64'(dbg_state), 64'(ST_REQ));
      n = 0;
      while (dbg_state == ST_REQ && n < 64) begin
        chk($sformatf("v%0d_req", idx), 64'(dmem_req), 64'd1);
        chk($sformatf("v%0d_addr", idx), 64'(dmem_addr), 64'(v.exp_addr));
        chk($sformatf("v%0d_be", idx), 64'(dmem_be), 64'(v.exp_be));
        chk($sformatf("v%0d_we", idx), 64'(dmem_we), 64'(v.op == OP_STORE));
        if (v.op == OP_STORE) chk($sformatf("v%0d_wdata", idx), 64'(dmem_wdata), 64'(v.exp_wdata));
        chk($sformatf("v%0d_req_pc", idx), 64'(pc_enable), 64'd0);
        n++;
        if (n == wn) begin
          dmem_ready = 1'b1;
          dmem_rdata = v.rdata;
        end
        step();
        dmem_ready = 1'b0;
        dmem_rdata = $urandom;
      end
      chk($sformatf("v%0d_req_cycles", idx), 64'(n), 64'(wn));
    end
    chk($sformatf("v%0d_state_done", idx), 64'(dbg_state), 64'(ST_DONE));
    chk($sformatf("v%0d_done_pc", idx), 64'(pc_enable), 64'd1);
    chk($sformatf("v%0d_done_rwo", idx), 64'(reg_write_out), 64'(v.exp_rwo));
    chk($sformatf("v%0d_done_mis", idx), 64'(misalign_err), 64'(v.exp_mis));
    chk($sformatf("v%0d_done_req", idx), 64'(dmem_req), 64'd0);
    if (v.exp_req && v.op == OP_LOAD) begin
      if (exp_q.size() == 0) begin
        chk($sformatf("v%0d_queue_empty", idx), 64'd0, 64'd1);
      end else begin
        chk($sformatf("v%0d_load_data", idx), 64'(load_data), 64'(exp_q.pop_front()));
      end
    end
    drive_idle();
    step();
    chk($sformatf("v%0d_back_idle", idx), 64'(dbg_state), 64'(ST_IDLE));
  endtask

  initial begin
    //                op        f3     rwi addr          wdata         rdata         wait eq  eaddr         be       ewdata        eload         rwo  mis
    vecs[0]  = mk(OP_LOAD,  F3_W,  1, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 3, 1, 32'h0000_1000, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1, 0);
    vecs[1]  = mk(OP_LOAD,  F3_B,  1, 32'h0000_1003, 32'h0,        32'h8012_3456, 1, 1, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFF_FF80, 1, 0);
    vecs[2]  = mk(OP_LOAD,  F3_BU, 1, 32'h0000_1003, 32'h0,        32'h8012_3456, 2, 1, 32'h0000_1000, 4'b1000, 32'h0,        32'h0000_0080, 1, 0);
    vecs[3]  = mk(OP_STORE, F3_H,  1, 32'h0000_2002, 32'h0000_ABCD, 32'h0,        2, 1, 32'h0000_2000, 4'b1100, 32'hABCD_0000, 32'h0,        0, 0);
    vecs[4]  = mk(OP_LOAD,  F3_W,  1, 32'h0000_1001, 32'h0,        32'h0,        1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 1);
    vecs[5]  = mk(OP_LOAD,  F3_H,  1, 32'h0000_3002, 32'h0,        32'h8001_1234, 0, 1, 32'h0000_3000, 4'b1100, 32'h0,        32'hFFFF_8001, 1, 0);
    vecs[6]  = mk(OP_LOAD,  F3_HU, 1, 32'h0000_3002, 32'h0,        32'h8001_1234, 0, 1, 32'h0000_3000, 4'b1100, 32'h0,        32'h0000_8001, 1, 0);
    vecs[7]  = mk(OP_STORE, F3_B,  0, 32'h0000_4001, 32'h1234_5678, 32'h0,        0, 1, 32'h0000_4000, 4'b0010, 32'h3456_7800, 32'h0,        0, 0);
    vecs[8]  = mk(OP_LOAD,  F3_H,  1, 32'h0000_3001, 32'h0,        32'h0,        1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 1);
    vecs[9]  = mk(OP_LOAD,  F3_D,  1, 32'h0000_5000, 32'h0,        32'h0,        1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 1);
    vecs[10] = mk(OP_STORE, F3_W,  1, 32'h0000_6004, 32'hCAFE_F00D, 32'h0,        4, 1, 32'h0000_6004, 4'b1111, 32'hCAFE_F00D, 32'h0,        0, 0);
    vecs[11] = mk(OP_LOAD,  F3_B,  1, 32'h0000_7000, 32'h0,        32'h1234_5678, 1, 1, 32'h0000_7000, 4'b0001, 32'h0,        32'h0000_0078, 1, 0);
    vecs[12] = mk(OP_LOAD,  F3_B,  1, 32'h0000_7001, 32'h0,        32'h1234_5678, 0, 1, 32'h0000_7000, 4'b0010, 32'h0,        32'h0000_0056, 1, 0);
    vecs[13] = mk(OP_LOAD,  F3_W,  0, 32'h0000_8008, 32'h0,        32'h0BAD_F00D, 2, 1, 32'h0000_8008, 4'b1111, 32'h0,        32'h0BAD_F00D, 0, 0);
    vecs[14] = mk(OP_LOAD,  F3_WU, 1, 32'h0000_9000, 32'h0,        32'h0,        1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 1);

    // Reset block
    rst = 1'b1;
    opcode = OP_ADD; funct3 = 3'b000; reg_write_in = 1'b1;
    addr = '0; wdata_in = '0; dmem_ready = 1'b0; dmem_rdata = '0;
    repeat (3) step();
    chk("rst_pc", 64'(pc_enable), 64'd0);
    chk("rst_rwo", 64'(reg_write_out), 64'd0);
    chk("rst_req", 64'(dmem_req), 64'd0);
    chk("rst_addr", 64'(dmem_addr), 64'd0);
    chk("rst_be", 64'(dmem_be), 64'd0);
    chk("rst_we", 64'(dmem_we), 64'd0);
    chk("rst_load", 64'(load_data), 64'd0);
    chk("rst_mis", 64'(misalign_err), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;

    // Single-cycle ALU op, with a stray dmem_ready that must be ignored
    opcode = OP_ADD; reg_write_in = 1'b1; dmem_ready = 1'b1;
    #1;
    chk("add_pc", 64'(pc_enable), 64'd1);
    chk("add_rwo", 64'(reg_write_out), 64'd1);
    chk("add_req", 64'(dmem_req), 64'd0);
    step();
    chk("add_stay_idle", 64'(dbg_state), 64'(ST_IDLE));
    chk("add_req_after", 64'(dmem_req), 64'd0);
    drive_idle();

    for (int i = 0; i < NV; i++) do_access(i, vecs[i]);

    // Reset while a load is waiting in REQ
    opcode = OP_LOAD; funct3 = F3_W; reg_write_in = 1'b1; addr = 32'h0000_A000;
    step();
    chk("rreq_req", 64'(dmem_req), 64'd1);
    rst = 1'b1;
    dmem_rdata = 32'h1111_2222;
    step();
    chk("rreq_req_drop", 64'(dmem_req), 64'd0);
    chk("rreq_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rreq_pc", 64'(pc_enable), 64'd0);
    chk("rreq_load", 64'(load_data), 64'd0);
    rst = 1'b0;
    drive_idle();
    step();
    do_access(100, vecs[0]);

`ifdef DMEM_TIMEOUT_EN
    // Memory never answers: 16 REQ cycles then DONE with bus_err
    begin
      int n;
      opcode = OP_LOAD; funct3 = F3_W; reg_write_in = 1'b1; addr = 32'h0000_B000;
      dmem_ready = 1'b0;
      step();
      n = 0;
      while (dbg_state == ST_REQ && n < 100) begin
        n++;
        step();
      end
      chk("tmo_req_cycles", 64'(n), 64'd16);
      chk("tmo_state", 64'(dbg_state), 64'(ST_DONE));
      chk("tmo_bus_err", 64'(bus_err), 64'd1);
      chk("tmo_rwo", 64'(reg_write_out), 64'd0);
      chk("tmo_pc", 64'(pc_enable), 64'd1);
      drive_idle();
      step();
      chk("tmo_bus_err_clr", 64'(bus_err), 64'd0);
    end
`endif

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
